soc_region_reader: RTL and testbench
====================================

SOC_REGION_READER -- requirements
Module: soc_region_reader

Interface
REQ-001 Parameter NUM_ENTRIES, default 1: number of sampled-counter RAM entries to read out, legal range 1..32.
REQ-002 Parameter RD_LAT, default 1: RAM read latency in clk_sample cycles from addr_o change to valid data_i, legal values 0..2.
REQ-003 clk_sample  input  1  readout clock, same clock as the sample RAM; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  single-cycle request to begin one full readout frame.
REQ-006 abort_i  input  1  synchronous request to abandon the current frame.
REQ-007 addr_o  output  5  RAM read address, registered.
REQ-008 data_i  input  24  RAM read data for addr_o.
REQ-009 ser_data_o  output  1  serial output bit.
REQ-010 ser_valid_o  output  1  ser_data_o holds a valid bit.
REQ-011 ser_ready_i  input  1  downstream accepts the bit this cycle.
REQ-012 ser_last_o  output  1  current bit is the final bit of the frame.
REQ-013 busy_o  output  1  a frame is in progress.
REQ-014 done_o  output  1  one-cycle pulse on frame completion.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, FETCH, SHIFT and DONE.
REQ-016 IDLE: start_i=1 SHALL set addr_o=0, clear the wait counter and enter FETCH; start_i SHALL be ignored in all other states.
REQ-017 FETCH SHALL last exactly RD_LAT+1 cycles; on its last cycle the block SHALL load a 29-bit shift register with {addr_o, data_i} and enter SHIFT.
REQ-018 SHIFT: ser_valid_o=1 and ser_data_o=shift register bit 28, giving MSB-first order with the 5 address bits first and the 24 data bits after.
REQ-019 A bit transfers only when ser_valid_o=1 and ser_ready_i=1; on a transfer the register SHALL shift left by one and the bit counter SHALL increment.
REQ-020 While ser_ready_i=0, ser_data_o and ser_valid_o SHALL remain stable. Abort is the only exception.
REQ-021 After the 29th transfer of an entry: if addr_o < NUM_ENTRIES-1, the block SHALL increment addr_o and enter FETCH; otherwise it SHALL enter DONE.
REQ-022 ser_last_o SHALL be 1 only while in SHIFT with addr_o = NUM_ENTRIES-1 and bit counter = 28.
REQ-023 DONE SHALL last one cycle with done_o=1 and busy_o=0, then return to IDLE.
REQ-024 busy_o SHALL be 1 in FETCH and SHIFT only.
REQ-025 abort_i=1 in FETCH or SHIFT SHALL return the FSM to IDLE on the next edge, with ser_valid_o=0, addr_o=0 and no done_o pulse; abort_i SHALL have no effect in IDLE or DONE.
REQ-026 If abort_i and a transfer occur in the same cycle, abort SHALL take priority and that bit SHALL be counted as delivered but the frame discarded.
REQ-027 addr_o SHALL never exceed NUM_ENTRIES-1; the bit counter is 5 bits and SHALL reset to 0 on each entry load.
REQ-028 With ser_ready_i held at 1, frame length SHALL be NUM_ENTRIES*(RD_LAT+1+29) cycles from the edge after start_i to the DONE cycle, excluding the DONE cycle.

Reset
REQ-029 rstn=0 SHALL asynchronously force the FSM to IDLE.
REQ-030 rstn=0 SHALL force addr_o=0, ser_data_o=0, ser_valid_o=0, ser_last_o=0, busy_o=0, done_o=0, and clear the shift register and all counters.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for a new start_i.

Verification
REQ-032 NUM_ENTRIES=1, RD_LAT=1, RAM[0]=24'hABCDEF, ready=1, start pulse -> ser_valid_o rises 2 cycles after start; bits are 00000 then 101010111100110111101111; ser_last_o is on bit 29; done_o pulses the next cycle.
REQ-033 NUM_ENTRIES=3, RD_LAT=0, RAM[i]=i+1, ready=1 -> three 29-bit words with tags 0, 1, 2; 90 busy cycles; one done_o pulse.
REQ-034 NUM_ENTRIES=2, ser_ready_i toggling 1/0 each cycle -> identical bit sequence to the ready=1 run; ser_data_o is stable during every ready=0 cycle.
REQ-035 Abort at bit 10 of entry 1 (NUM_ENTRIES=4) -> ser_valid_o=0 and addr_o=0 next cycle, no done_o; a following start_i restarts the frame from entry 0.
REQ-036 start_i re-pulsed while busy, plus rstn pulsed low mid-SHIFT -> the re-pulse is ignored; on reset all outputs go to 0 immediately and the block stays IDLE until the next start_i.

Source files
------------

// File: rtl/soc_region_reader.sv
// Reads NUM_ENTRIES sampled-counter RAM words and serialises each one as a
// 29-bit {address, data} word, MSB first, over a valid/ready bit stream.
module soc_region_reader #(
    parameter int unsigned NUM_ENTRIES = 1,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic        clk_sample,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [4:0]  addr_o,
    input  logic [23:0] data_i,
    output logic        ser_data_o,
    output logic        ser_valid_o,
    input  logic        ser_ready_i,
    output logic        ser_last_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

    localparam logic [4:0] LastAddr = 5'(NUM_ENTRIES - 1);
    localparam logic [1:0] LastWait = 2'(RD_LAT);
    localparam logic [4:0] LastBit  = 5'd28;

    state_e      stateQ, stateD;
    logic [4:0]  addrQ, addrD;
    logic [1:0]  waitQ, waitD;
    logic [4:0]  bitCntQ, bitCntD;
    logic [28:0] shiftQ, shiftD;
    logic        xfer;

    always_ff @(posedge clk_sample or negedge rstn) begin
        if (!rstn) begin
            stateQ  <= StIdle;
            addrQ   <= '0;
            waitQ   <= '0;
            bitCntQ <= '0;
            shiftQ  <= '0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            waitQ   <= waitD;
            bitCntQ <= bitCntD;
            shiftQ  <= shiftD;
        end
    end

    assign xfer = (stateQ == StShift) && ser_ready_i;

    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        waitD   = waitQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        unique case (stateQ)
            StIdle: begin
                if (start_i) begin
                    stateD = StFetch;
                    addrD  = '0;
                    waitD  = '0;
                end
            end
            StFetch: begin
                if (abort_i) begin
                    stateD = StIdle;
                    addrD  = '0;
                    waitD  = '0;
                end else if (waitQ == LastWait) begin
                    // RAM output is valid for addrQ on this cycle
                    shiftD  = {addrQ, data_i};
                    bitCntD = '0;
                    waitD   = '0;
                    stateD  = StShift;
                end else begin
                    waitD = waitQ + 2'd1;
                end
            end
            StShift: begin
                if (xfer) begin
                    shiftD  = {shiftQ[27:0], 1'b0};
                    bitCntD = bitCntQ + 5'd1;
                end
                // Abort wins over end-of-word; a bit accepted this cycle is dropped with the frame
                if (abort_i) begin
                    stateD = StIdle;
                    addrD  = '0;
                end else if (xfer && (bitCntQ == LastBit)) begin
                    if (addrQ < LastAddr) begin
                        addrD  = addrQ + 5'd1;
                        waitD  = '0;
                        stateD = StFetch;
                    end else begin
                        stateD = StDone;
                    end
                end
            end
            StDone: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    assign addr_o      = addrQ;
    assign ser_valid_o = (stateQ == StShift);
    assign ser_data_o  = ser_valid_o & shiftQ[28];
    assign ser_last_o  = ser_valid_o && (addrQ == LastAddr) && (bitCntQ == LastBit);
    assign busy_o      = (stateQ == StFetch) || (stateQ == StShift);
    assign done_o      = (stateQ == StDone);

endmodule

// File: tb/tb_soc_region_reader.sv
// Bench for soc_region_reader: three instances with different entry counts and
// read latencies, a bit-level scoreboard, and directed abort/reset sequences.
module tb_soc_region_reader;

    typedef struct packed {logic d; logic l;} exp_bit_t;
    typedef struct {int k; int mode; int expBusy;} vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [2:0]  start, abortR, ready;
    logic [2:0]  serData, serValid, serLast, busy, done;
    logic [4:0]  addr0, addr1, addr2;
    logic [23:0] data0, data1, data2, stage2;

    int ne [3] = '{1, 3, 4};
    int lat[3] = '{1, 0, 2};

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int xferCnt = 0;
    exp_bit_t expQ[$];

    logic held, heldD, heldL;

    soc_region_reader #(.NUM_ENTRIES(1), .RD_LAT(1)) dut0 (
        .clk_sample(clk), .rstn(rstn), .start_i(start[0]), .abort_i(abortR[0]),
        .addr_o(addr0), .data_i(data0), .ser_data_o(serData[0]), .ser_valid_o(serValid[0]),
        .ser_ready_i(ready[0]), .ser_last_o(serLast[0]), .busy_o(busy[0]), .done_o(done[0])
    );
    soc_region_reader #(.NUM_ENTRIES(3), .RD_LAT(0)) dut1 (
        .clk_sample(clk), .rstn(rstn), .start_i(start[1]), .abort_i(abortR[1]),
        .addr_o(addr1), .data_i(data1), .ser_data_o(serData[1]), .ser_valid_o(serValid[1]),
        .ser_ready_i(ready[1]), .ser_last_o(serLast[1]), .busy_o(busy[1]), .done_o(done[1])
    );
    soc_region_reader #(.NUM_ENTRIES(4), .RD_LAT(2)) dut2 (
        .clk_sample(clk), .rstn(rstn), .start_i(start[2]), .abort_i(abortR[2]),
        .addr_o(addr2), .data_i(data2), .ser_data_o(serData[2]), .ser_valid_o(serValid[2]),
        .ser_ready_i(ready[2]), .ser_last_o(serLast[2]), .busy_o(busy[2]), .done_o(done[2])
    );

    function automatic logic [23:0] ramF(input int k, input logic [4:0] a);
        case (k)
            0:       ramF = (a == 5'd0) ? 24'hABCDEF : 24'hDEAD00;
            1:       ramF = 24'(a) + 24'd1;
            default: ramF = {a, a ^ 5'h1F, a, 9'h15A};
        endcase
    endfunction

    // RAM models with the read latency each instance is configured for
    always @(posedge clk) data0 <= ramF(0, addr0);
    assign data1 = ramF(1, addr1);
    always @(posedge clk) begin
        stage2 <= ramF(2, addr2);
        data2  <= stage2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fillExp(input int k);
        logic [28:0] w;
        expQ.delete();
        for (int a = 0; a < ne[k]; a++) begin
            w = {5'(a), ramF(k, 5'(a))};
            for (int b = 28; b >= 0; b--) begin
                expQ.push_back('{d: w[b], l: (a == ne[k] - 1) && (b == 0)});
            end
        end
    endtask

    // Scoreboard: pops one expected bit per accepted transfer, checks hold stability
    always @(negedge clk) begin
        logic v, r, d, l;
        exp_bit_t e;
        v = serValid[sel];
        r = ready[sel];
        d = serData[sel];
        l = serLast[sel];
        if (!rstn) begin
            held = 1'b0;
        end else begin
            if (held && v) begin
                check("hold_data", 32'(d), 32'(heldD));
                check("hold_last", 32'(l), 32'(heldL));
            end
            held  = v && !r;
            heldD = d;
            heldL = l;
            if (v && r) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_bit: got bit %0b with no expected bit left", d);
                end else begin
                    e = expQ.pop_front();
                    check("ser_bit", 32'(d), 32'(e.d));
                    check("ser_last", 32'(l), 32'(e.l));
                end
                xferCnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input int k);
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    // mode 0: ready held high, 1: toggles 1/0, 2: random
    task automatic runFrame(input int k, input int mode, input int expBusy);
        int busyCnt = 0, doneCnt = 0, firstV = -1;
        bit fin = 1'b0;
        sel = k;
        xferCnt = 0;
        fillExp(k);
        ready[k] = 1'b1;
        pulseStart(k);
        for (int c = 1; c <= 3000 && !fin; c++) begin
            ready[k] = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy[k]) busyCnt++;
            if (serValid[k] && firstV < 0) firstV = c;
            if (done[k]) begin
                doneCnt++;
                fin = 1'b1;
                check("done_busy_low", 32'(busy[k]), 0);
            end
            step();
        end
        check("frame_finished", 32'(fin), 1);
        @(negedge clk);
        check("done_one_cycle", 32'(done[k]), 0);
        check("idle_after_done", 32'({busy[k], serValid[k]}), 0);
        check("done_count", doneCnt, 1);
        check("bits_left", expQ.size(), 0);
        check("valid_latency", firstV, lat[k] + 2);
        if (expBusy >= 0) check("busy_cycles", busyCnt, expBusy);
        ready[k] = 1'b0;
        step();
    endtask

    initial begin
        vec_t vecs[6];
        int guard;
        logic seen;
        vecs[0] = '{k: 0, mode: 0, expBusy: 31};
        vecs[1] = '{k: 1, mode: 0, expBusy: 90};
        vecs[2] = '{k: 2, mode: 0, expBusy: 128};
        vecs[3] = '{k: 1, mode: 1, expBusy: -1};
        vecs[4] = '{k: 2, mode: 2, expBusy: -1};
        vecs[5] = '{k: 0, mode: 1, expBusy: -1};

        rstn = 1'b0;
        start = '0;
        abortR = '0;
        ready = '0;
        #3;
        check("reset_flags", 32'({serData, serValid, serLast, busy, done}), 0);
        check("reset_addr", 32'({addr0, addr1, addr2}), 0);
        step();
        rstn = 1'b1;
        repeat (3) step();
        check("idle_no_busy", 32'(busy), 0);

        for (int i = 0; i < 6; i++) runFrame(vecs[i].k, vecs[i].mode, vecs[i].expBusy);

        // Abort on entry 1 bit 10, coincident with a transfer
        sel = 2;
        xferCnt = 0;
        fillExp(2);
        ready[2] = 1'b1;
        pulseStart(2);
        guard = 0;
        while (xferCnt != 39 && guard < 400) begin
            step();
            guard++;
        end
        check("abort_reach", xferCnt, 39);
        check("abort_addr_before", 32'(addr2), 1);
        abortR[2] = 1'b1;
        step();
        abortR[2] = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(serValid[2]), 0);
        check("abort_addr", 32'(addr2), 0);
        check("abort_busy", 32'(busy[2]), 0);
        seen = done[2];
        repeat (5) begin
            @(negedge clk);
            seen |= done[2] | busy[2];
        end
        check("abort_no_done", 32'(seen), 0);
        ready[2] = 1'b0;
        step();
        runFrame(2, 0, 128);

        // Start re-pulsed while busy, then reset asserted mid-SHIFT
        sel = 1;
        xferCnt = 0;
        fillExp(1);
        ready[1] = 1'b1;
        pulseStart(1);
        repeat (15) step();
        pulseStart(1);
        repeat (20) step();
        check("pre_reset_valid", 32'(serValid[1]), 1);
        check("pre_reset_addr", 32'(addr1), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_flags", 32'({serData[1], serValid[1], serLast[1], busy[1], done[1]}), 0);
        check("async_reset_addr", 32'(addr1), 0);
        step();
        rstn = 1'b1;
        expQ.delete();
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= busy[1] | serValid[1] | done[1];
        end
        check("idle_after_reset", 32'(seen), 0);
        ready[1] = 1'b0;
        step();
        runFrame(1, 0, 90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
